// File: rtl/decoder_scan_pkg.sv
// Shared types and helpers for the scanning active-low decoder.
package decoder_scan_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    localparam int unsigned MAX_N = 32;

    typedef enum logic [1:0] {S_OFF, S_SHOW, S_BLANK} state_t;

    // Active-low one-hot for up to 32 lines; en_l high forces all lines off.
    function automatic logic [MAX_N-1:0] onehot_l(input logic [4:0] sel, input logic en_l);
        logic [MAX_N-1:0] y;
        y = '1;
        if (!en_l) begin
            y[sel] = 1'b0;
        end
        return y;
    endfunction

endpackage

// File: rtl/dec_n_l.sv
// Combinational SEL_W-to-2^SEL_W decoder, active-low enable and active-low outputs.
module dec_n_l import decoder_scan_pkg::*; #(
    parameter int unsigned SEL_W = 2
) (
    input  logic [SEL_W-1:0]      sel_i,
    input  logic                  g_l_i,
    output logic [(1<<SEL_W)-1:0] y_l_o
);

    localparam int unsigned N = 1 << SEL_W;

    assign y_l_o = N'(onehot_l(5'(sel_i), g_l_i));

endmodule

// File: rtl/decoder_scan_l.sv
// Registered active-low decoder with direct mode and a dwell/blank scan sequencer.
module decoder_scan_l import decoder_scan_pkg::*; #(
    parameter int unsigned SEL_W     = 2,
    parameter int unsigned DWELL_W   = 8,
    parameter int unsigned BLANK_CYC = 1
) (
    input  logic                  CLK,
    input  logic                  RESET_L,
    input  logic                  G_L,
    input  logic                  MODE,
    input  logic [SEL_W-1:0]      SEL,
    input  logic [DWELL_W-1:0]    DWELL,
    output logic [(1<<SEL_W)-1:0] Y_L,
    output logic [SEL_W-1:0]      IDX,
    output logic                  WRAP
);

    localparam int unsigned N  = 1 << SEL_W;
    localparam int unsigned BW = (BLANK_CYC > 0) ? $clog2(BLANK_CYC + 1) : 1;
    localparam logic [BW-1:0]    BLANK_LAST = BW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
    localparam logic [SEL_W-1:0] IDX_LAST   = SEL_W'(N - 1);

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    idx_q, idx_d;
    logic [DWELL_W-1:0]  cnt_q, cnt_d;
    logic [DWELL_W-1:0]  dwell_lim_q, dwell_lim_d;
    logic [BW-1:0]       blank_q, blank_d;
    logic                wrap_q, wrap_d;
    logic                off_l_d;
    logic                advance;
    logic [N-1:0]        dec_y;
    logic [N-1:0]        y_l_q;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        dwell_lim_d = dwell_lim_q;
        blank_d     = blank_q;
        wrap_d      = 1'b0;
        off_l_d     = 1'b1;
        advance     = 1'b0;

        if (G_L) begin
            state_d = S_OFF;
            idx_d   = '0;
            cnt_d   = '0;
            blank_d = '0;
        end else if (MODE == MODE_DIRECT) begin
            state_d = S_OFF;
            idx_d   = SEL;
            cnt_d   = '0;
            blank_d = '0;
            off_l_d = 1'b0;
        end else begin
            unique case (state_q)
                S_OFF: begin
                    state_d     = S_SHOW;
                    idx_d       = '0;
                    dwell_lim_d = DWELL;
                    cnt_d       = '0;
                    blank_d     = '0;
                    off_l_d     = 1'b0;
                end
                S_SHOW: begin
                    if (cnt_q == dwell_lim_q) begin
                        if (BLANK_CYC > 0) begin
                            state_d = S_BLANK;
                            blank_d = '0;
                        end else begin
                            advance = 1'b1;
                        end
                    end else begin
                        cnt_d   = cnt_q + DWELL_W'(1);
                        off_l_d = 1'b0;
                    end
                end
                S_BLANK: begin
                    if (blank_q == BLANK_LAST) begin
                        advance = 1'b1;
                    end else begin
                        blank_d = blank_q + BW'(1);
                    end
                end
                default: state_d = S_OFF;
            endcase

            // Next line asserts on the same edge the previous slot ends.
            if (advance) begin
                state_d     = S_SHOW;
                idx_d       = idx_q + SEL_W'(1);
                wrap_d      = (idx_q == IDX_LAST);
                dwell_lim_d = DWELL;
                cnt_d       = '0;
                off_l_d     = 1'b0;
            end
        end
    end

    dec_n_l #(
        .SEL_W(SEL_W)
    ) u_dec (
        .sel_i(idx_d),
        .g_l_i(off_l_d),
        .y_l_o(dec_y)
    );

    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            state_q     <= S_OFF;
            idx_q       <= '0;
            cnt_q       <= '0;
            dwell_lim_q <= '0;
            blank_q     <= '0;
            wrap_q      <= 1'b0;
            y_l_q       <= '1;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            dwell_lim_q <= dwell_lim_d;
            blank_q     <= blank_d;
            wrap_q      <= wrap_d;
            y_l_q       <= dec_y;
        end
    end

    assign Y_L  = y_l_q;
    assign IDX  = idx_q;
    assign WRAP = wrap_q;

endmodule
